// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one stage ALU among requesters.
// One op in flight at a time; a watchdog forces an error response.
module alu_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int TIMEOUT    = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ACTION_LEN-1:0] req_action,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    output logic [ACTION_LEN-1:0]         alu_action,
    output logic                          alu_action_valid,
    output logic [DATA_WIDTH-1:0]         alu_operand_1,
    output logic [DATA_WIDTH-1:0]         alu_operand_2,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_result_valid,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [7:0]                    drop_cnt
);

    localparam int TW  = $clog2(TIMEOUT) + 1;
    localparam int IW1 = ID_W + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] w_win;
    logic [IW1-1:0]  w_idx;
    logic            w_found;
    logic            w_grant;
    logic            w_done;
    logic [TW-1:0]   r_timer;

    // Find first valid requester at or above r_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IW1'(r_ptr) + IW1'(k);
            if (w_idx >= IW1'(NUM_REQ))
                w_idx = w_idx - IW1'(NUM_REQ);
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_grant   = (r_state == S_IDLE) && w_found;
    assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;
    assign w_done    = (r_state == S_WAIT) && (w_next == S_RESP);
    assign busy      = (r_state != S_IDLE);

    // Next-state logic; a result beats a simultaneous timeout.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (alu_result_valid || r_timer == TMAX)
                         w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Latch the winner's payload and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_action       <= '0;
            alu_operand_1    <= '0;
            alu_operand_2    <= '0;
            alu_action_valid <= 1'b0;
            r_id             <= '0;
            r_ptr            <= '0;
        end else begin
            alu_action_valid <= w_grant;
            if (w_grant) begin
                alu_action    <= req_action[int'(w_win)*ACTION_LEN +: ACTION_LEN];
                alu_operand_1 <= req_op1[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                alu_operand_2 <= req_op2[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_id          <= w_win;
                if (w_win == ID_W'(NUM_REQ - 1)) r_ptr <= '0;
                else                             r_ptr <= w_win + 1'b1;
            end
        end
    end

    // Watchdog timer, cleared on issue and counting while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= '0;
        else if (r_state == S_ISSUE)
            r_timer <= '0;
        else if (r_state == S_WAIT && !alu_result_valid && r_timer != TMAX)
            r_timer <= r_timer + 1'b1;
    end

    // Response register: one-cycle pulse, data zeroed on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= w_done;
            if (w_done) begin
                rsp_id   <= r_id;
                rsp_data <= alu_result_valid ? alu_result : '0;
                rsp_err  <= !alu_result_valid;
            end
        end
    end

    // Count results that arrive when nobody is waiting for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (alu_result_valid && r_state != S_WAIT && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the shared-ALU arbiter.
module tb_alu_share_arbiter;

    localparam int N  = 4;
    localparam int AL = 25;
    localparam int DW = 48;
    localparam int TO = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AL-1:0] req_action;
    logic [N*DW-1:0] req_op1;
    logic [N*DW-1:0] req_op2;
    logic [AL-1:0]   alu_action;
    logic            alu_action_valid;
    logic [DW-1:0]   alu_operand_1;
    logic [DW-1:0]   alu_operand_2;
    logic [DW-1:0]   alu_result = '0;
    logic            alu_result_valid = 1'b0;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;
    logic [7:0]      drop_cnt;

    logic [AL-1:0] act [N];
    logic [DW-1:0] o1  [N];
    logic [DW-1:0] o2  [N];
    logic [AL-1:0] dir_act [N];
    logic [DW-1:0] dir_o1  [N];
    logic [DW-1:0] dir_o2  [N];
    logic [N-1:0]  dir_mask = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_action[i*AL +: AL] = act[i];
            req_op1[i*DW +: DW]    = o1[i];
            req_op2[i*DW +: DW]    = o2[i];
        end
    end

    alu_share_arbiter #(
        .NUM_REQ(N), .ACTION_LEN(AL), .DATA_WIDTH(DW),
        .TIMEOUT(TO), .ID_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_action(req_action), .req_op1(req_op1), .req_op2(req_op2),
        .alu_action(alu_action), .alu_action_valid(alu_action_valid),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .drop_cnt(drop_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rnd   = 0;
    bit spam  = 0;
    int fix_d = 3;

    bit            m_busy = 0;
    int            m_tg, m_rsp, m_ptr;
    int            m_id;
    logic [AL-1:0] m_act;
    logic [DW-1:0] m_o1, m_o2, m_data;
    bit            m_err;
    int            alu_t = -1;
    logic [DW-1:0] alu_val;
    int            exp_drop = 0;
    logic [N-1:0]  granted = '0;
    int            g_id[$];
    int            g_cyc[$];
    int            n_rsp = 0;
    int            last_rsp_cyc;
    logic [DW-1:0] last_rsp_data;
    logic          last_rsp_err;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Winner = valid requester at smallest circular distance from ptr.
    function automatic int winner(input logic [N-1:0] v, input int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++)
            if (v[i] && ((i - p + N) % N) < bd) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic step();
        int w;
        int d;
        logic [N-1:0] e;
        bit ev;
        @(negedge clk);
        cyc++;
        if (rnd) begin
            for (int i = 0; i < N; i++)
                if (granted[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 40);
                    act[i] = AL'($urandom());
                    o1[i]  = DW'({$urandom(), $urandom()});
                    o2[i]  = DW'({$urandom(), $urandom()});
                end else if ($urandom_range(0, 99) < 5) begin
                    req_valid[i] = 1'b0;
                end
        end else begin
            req_valid = dir_mask;
            for (int i = 0; i < N; i++) begin
                act[i] = dir_act[i];
                o1[i]  = dir_o1[i];
                o2[i]  = dir_o2[i];
            end
        end
        alu_result_valid = spam || (cyc == alu_t);
        alu_result       = alu_val;
        #1;
        w = m_busy ? -1 : winner(req_valid, m_ptr);
        e = (w >= 0) ? (N'(1) << w) : '0;
        chk("req_ready", req_ready, e);
        chk("busy", busy, m_busy);
        chk("drop_cnt", drop_cnt, exp_drop);
        granted = req_ready;
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        if (alu_result_valid &&
            !(m_busy && cyc >= m_tg + 2 && cyc < m_rsp) && exp_drop < 255)
            exp_drop++;
        ev = m_busy && (cyc == m_tg + 1);
        chk("alu_valid", alu_action_valid, ev);
        if (ev) begin
            chk("alu_action", alu_action, m_act);
            chk("alu_op1", alu_operand_1, m_o1);
            chk("alu_op2", alu_operand_2, m_o2);
            if (fix_d > 0) d = fix_d;
            else if ($urandom_range(0, 9) < 7) d = $urandom_range(1, TO);
            else d = $urandom_range(TO + 1, TO + 3);
            alu_t   = cyc + d;
            alu_val = m_o1 + m_o2;
            m_err   = (d > TO);
            m_data  = m_err ? '0 : alu_val;
            m_rsp   = cyc + (m_err ? TO : d) + 1;
        end
        ev = m_busy && (cyc == m_rsp);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_err", rsp_err, m_err);
            m_busy = 0;
        end
        if (rsp_valid) begin
            n_rsp++;
            last_rsp_cyc  = cyc;
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_err;
        end
        if (w >= 0) begin
            m_busy = 1;
            m_tg   = cyc;
            m_id   = w;
            m_act  = act[w];
            m_o1   = o1[w];
            m_o2   = o2[w];
            m_ptr  = (w + 1) % N;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        alu_result_valid = 1'b0;
        #1;
        chk("rst_alu_valid", alu_action_valid, 0);
        chk("rst_alu_action", alu_action, 0);
        chk("rst_alu_op1", alu_operand_1, 0);
        chk("rst_alu_op2", alu_operand_2, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        m_busy   = 0;
        m_ptr    = 0;
        alu_t    = -1;
        exp_drop = 0;
        granted  = '0;
        spam     = 0;
        dir_mask = '0;
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic one_op(input int id, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int waitn);
        dir_act[id] = {4'b0001, 21'h0_1234};
        dir_o1[id]  = a;
        dir_o2[id]  = b;
        dir_mask    = N'(1) << id;
        step();
        dir_mask = '0;
        repeat (waitn) step();
    endtask

    initial begin
        int rsp0;
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            act[i] = '0; o1[i] = '0; o2[i] = '0;
            dir_act[i] = '0; dir_o1[i] = '0; dir_o2[i] = '0;
        end
        repeat (3) @(posedge clk);
        do_reset();

        // single op: 5 + 7
        fix_d = 3;
        rsp0 = n_rsp;
        one_op(0, 5, 7, 7);
        chk("single_lat", last_rsp_cyc - g_cyc[$], 5);
        chk("single_data", last_rsp_data, 12);
        chk("single_cnt", n_rsp - rsp0, 1);

        // round-robin with all requesters valid
        do_reset();
        g_id.delete(); g_cyc.delete();
        for (int i = 0; i < N; i++) begin
            dir_act[i] = AL'(i + 1);
            dir_o1[i]  = DW'(i);
            dir_o2[i]  = '0;
        end
        dir_mask = '1;
        repeat (26) step();
        dir_mask = '0;
        repeat (10) step();
        chk("rr_count", g_id.size(), 5);
        for (int i = 0; i < 5 && i < g_id.size(); i++)
            chk("rr_order", g_id[i], exp_rr[i]);
        for (int i = 0; i + 1 < g_cyc.size(); i++)
            chk("rr_gap", g_cyc[i+1] - g_cyc[i], 6);

        // pointer skip: ptr=2, req1/req3 valid
        do_reset();
        one_op(1, 1, 1, 7);
        g_id.delete(); g_cyc.delete();
        dir_mask = 4'b1010;
        repeat (12) step();
        dir_mask = '0;
        repeat (8) step();
        chk("skip_count", g_id.size(), 2);
        if (g_id.size() >= 2) begin
            chk("skip_first", g_id[0], 3);
            chk("skip_second", g_id[1], 1);
        end

        // timeout with a late result landing in IDLE
        do_reset();
        fix_d = TO + 2;
        rsp0 = n_rsp;
        one_op(2, 9, 9, 14);
        chk("to_lat", last_rsp_cyc - g_cyc[$], TO + 2);
        chk("to_err", last_rsp_err, 1);
        chk("to_data", last_rsp_data, 0);
        chk("to_cnt", n_rsp - rsp0, 1);
        chk("to_drop", drop_cnt, 1);

        // result collides with the last timer cycle
        fix_d = TO;
        one_op(3, 48'hABC, 0, 12);
        chk("col_err", last_rsp_err, 0);
        chk("col_data", last_rsp_data, 48'hABC);
        chk("col_lat", last_rsp_cyc - g_cyc[$], TO + 2);

        // reset in WAIT, ptr left at 3 beforehand
        fix_d = 3;
        do_reset();
        rsp0 = n_rsp;
        one_op(2, 33, 44, 1);
        chk("pre_rst_busy", busy, 1);
        do_reset();
        g_id.delete(); g_cyc.delete();
        dir_act[1] = 25'h1ABCDE; dir_o1[1] = 3; dir_o2[1] = 4;
        dir_act[3] = 25'h0ABCDE; dir_o1[3] = 5; dir_o2[3] = 6;
        dir_mask = 4'b1010;
        step();
        dir_mask = '0;
        repeat (7) step();
        chk("rst_no_rsp", n_rsp - rsp0, 1);
        if (g_id.size() >= 1) chk("rst_first", g_id[0], 1);
        else chk("rst_first", 32'hFFFF_FFFF, 1);

        // drop counter saturation
        do_reset();
        spam = 1;
        repeat (270) step();
        spam = 0;
        step();
        chk("drop_sat", drop_cnt, 255);

        // random traffic
        do_reset();
        fix_d = 0;
        rnd = 1;
        repeat (2000) step();
        rnd = 0;
        dir_mask = '0;
        repeat (16) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one stage ALU among NUM_REQ sub-action requesters in the action engine.
- Arbitrates round-robin and issues one action at a time to the ALU.
- Waits for the ALU's result pulse, then returns the result tagged with the requester ID.
- A timeout watchdog guarantees a response even if the ALU never answers.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- ACTION_LEN, 25, sub-action width; opcode in [ACTION_LEN-1:ACTION_LEN-4].
- DATA_WIDTH, 48, operand and result width.
- TIMEOUT, 8, maximum cycles spent in WAIT before an error response.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant, combinational
- req_action  in  NUM_REQ*ACTION_LEN  packed; requester i at [i*ACTION_LEN +: ACTION_LEN]
- req_op1  in  NUM_REQ*DATA_WIDTH  packed operand 1
- req_op2  in  NUM_REQ*DATA_WIDTH  packed operand 2
- alu_action  out  ACTION_LEN  to ALU action_in
- alu_action_valid  out  1  one-cycle issue pulse
- alu_operand_1  out  DATA_WIDTH  to ALU
- alu_operand_2  out  DATA_WIDTH  to ALU
- alu_result  in  DATA_WIDTH  from ALU container_out
- alu_result_valid  in  1  from ALU container_out_valid
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  ID_W  requester that owns the response
- rsp_data  out  DATA_WIDTH  ALU result; 0 on error
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high in any state other than IDLE
- drop_cnt  out  8  saturating count of unexpected alu_result_valid pulses

Behaviour:
- Reset: all of the following clear immediately (asynchronously):
  - state to IDLE, RR pointer to 0, timer to 0;
  - every registered output to 0: alu_action, alu_action_valid, alu operands, rsp_*, drop_cnt.
- Reset mid-operation abandons the in-flight op with no response. The ALU shares rst_n and resets with it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the first requester with req_valid set, searching from ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner] is high this cycle only; req_ready is all-zero in every other state.
  - On grant: latch action, op1 and op2 into the alu_* output registers; latch ID; ptr <= (winner+1) mod NUM_REQ; go to ISSUE.
  - With no request pending, stay in IDLE.
- ISSUE: alu_action_valid=1 for exactly this cycle; timer <= 0; go to WAIT.
- WAIT:
  - alu_action_valid=0.
  - If alu_result_valid: capture alu_result, err=0, go to RESP.
  - Else if timer==TIMEOUT-1: data=0, err=1, go to RESP.
  - Else timer++.
  - If a valid result and the timeout coincide, the result wins (err=0).
- RESP: rsp_valid=1 with rsp_id, rsp_data and rsp_err stable for this cycle; go to IDLE.
- Latency:
  - Grant at cycle T; issue at T+1.
  - The ALU returns its result at T+4 (3 cycles after issue).
  - rsp_valid at T+5; next grant possible at T+6.
  - Sustained throughput: one op per 6 cycles.
- Requester contract:
  - Hold req_valid and all payload until req_ready is seen.
  - req_valid may drop without a grant.
  - The payload is sampled only in the grant cycle.
- Stray result: alu_result_valid in any state other than WAIT (including a late result after a timeout) is discarded and drop_cnt increments, saturating at 255.
- Fairness: when all requesters are continuously valid, grants go 0,1,2,3,0,…; no requester waits more than NUM_REQ-1 grants.
- Operand and action bits pass through unmodified; the block does no arithmetic.

Test Plan:
- Single op: reset, then req0 with action opcode 0001, op1=5, op2=7; ALU model returns 12 three cycles after issue -> req_ready[0] at T, alu_action_valid at T+1, rsp_valid at T+5 with id=0, data=12, err=0.
- Round-robin: all 4 requesters held valid with op1=i -> grant order 0,1,2,3,0; exactly one req_ready bit per grant; grants spaced 6 cycles apart.
- Pointer skip: ptr=2, only req1 and req3 valid -> req3 granted first, then req1.
- Timeout: ALU model never responds -> rsp_valid at T+1+TIMEOUT+1 with err=1, data=0. A late alu_result_valid pulse arriving in IDLE -> drop_cnt=1 and no rsp_valid.
- Collision: alu_result_valid with data 0xABC in the cycle timer==TIMEOUT-1 -> rsp err=0, data=0xABC.
- Reset mid-WAIT: assert rst_n=0 one cycle after issue -> all outputs 0 immediately; no rsp_valid after release; next request granted normally, starting the search from ptr=0.
